lsu_subword: RTL
================

Name: lsu_subword

Overview:
- Load/store unit placed directly upstream of the word-only data memory.
- Accepts one load or store request from the core and applies the RV32I funct3 encoding.
- Sub-word stores become a read-modify-write of the containing word. Sub-word loads are extracted and sign- or zero-extended.
- Misaligned accesses and illegal funct3 values are flagged as errors and never touch memory.

Parameters:
XLEN, 32, data and address width
ERR_ON_MISALIGN, 1, 1 = misaligned access returns resp_err with no memory access; 0 = low address bits forced to the natural alignment

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  load result (0 for stores and errors)
resp_err  out  1  misaligned or illegal access, valid with resp_valid
dmem_a  out  XLEN  word address to memory, low 2 bits always 00
dmem_wd  out  XLEN  write word
dmem_we  out  1  memory write enable
dmem_rd  in  XLEN  combinational read word at dmem_a

Behaviour:
- Reset is asynchronous and active-low: clk and rstn, with rstn asynchronous active-low.
  - While rstn=0: state=IDLE, all registers cleared.
  - Outputs while rstn=0: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, dmem_a=0, dmem_wd=0, dmem_we=0.
- States: IDLE, ACCESS, WRITE, RESP.
- Handshake:
  - req_ready=1 only in IDLE with rstn=1.
  - A request is accepted on a rising edge with req_valid & req_ready. At that edge addr, funct3, we and wdata are latched.
  - req_valid without req_ready is ignored; the requester holds it.
- Error check at accept:
  - Errors: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}.
  - On error: next state RESP with resp_err=1.
  - On no error: next state ACCESS.
- ACCESS:
  - dmem_a = {addr[31:2],2'b00}.
  - Load: resp_rdata is registered from the extracted dmem_rd; next state RESP.
    - LB/LBU select byte lane addr[1:0].
    - LH/LHU select half-word lane addr[1].
    - Sign- or zero-extend to XLEN.
  - SW: dmem_we=1, dmem_wd=wdata this cycle; next state RESP.
  - SB/SH: dmem_rd is registered into a merge word, with the target lane replaced by wdata[7:0] or wdata[15:0]; next state WRITE.
- WRITE: dmem_we=1, dmem_a unchanged, dmem_wd = merge word; next state RESP.
- RESP: resp_valid=1 for exactly one cycle; next state IDLE. There is no response backpressure.
- Latency, counted from the accept edge to the cycle resp_valid is high:
  - Error: 1 cycle.
  - Load and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Back-to-back throughput: one request per latency+1 cycles.
- Write rules:
  - dmem_we is high for exactly one cycle per successful store and never for loads or errors.
  - Outside the write cycle dmem_wd=0.
  - dmem_a holds the latched aligned address in ACCESS, WRITE and RESP, and is 0 in IDLE.
- Reset mid-operation: the transaction is abandoned, with no response pulse. dmem_we drops combinationally, so asserting rstn before the write edge suppresses the memory write.
- ERR_ON_MISALIGN=0: addr is masked to natural alignment (H: bit0=0; W: bits1:0=0); no misalign error is raised.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB at 0x41 -> resp_rdata=0xFFFFFFAA two cycles after accept; LBU at 0x41 -> 0x000000AA; resp_err=0.
- Same word; LH at 0x42 -> 0xFFFF8899; LHU at 0x42 -> 0x00008899; LW at 0x40 -> 0x8899AABB.
- Word 0x40 = 0x8899AABB; SB 0x43 wdata=0x12345677 -> single dmem_we pulse in WRITE, dmem_wd=0x7799AABB, resp_valid 3 cycles after accept; SH 0x40 wdata=0xCAFE -> 0x7799CAFE.
- SW 0x44 wdata=0xDEADBEEF -> dmem_we in ACCESS, dmem_a=0x44, dmem_wd=0xDEADBEEF, resp 2 cycles after accept.
- Errors produce resp_err=1 one cycle after accept with no dmem_we: LW at 0x42, SH at 0x45, load funct3=011, store funct3=100.
- Reset mid-operation: accept SB at 0x48, drop rstn during ACCESS -> no dmem_we, no resp_valid, req_ready=0 while in reset; release rstn -> req_ready=1 and the next LW completes normally.

Source files
------------

// File: rtl/lsu_subword.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_subword
//  Description : Load/store unit in front of a word-only data memory. Applies
//                RV32I funct3 sizing: sub-word loads are lane-extracted and
//                sign/zero-extended, sub-word stores become a read-modify-write
//                of the containing word. Misaligned or illegal requests return
//                resp_err without touching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_subword #(
  parameter int XLEN            = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] dmem_a,
  output logic [XLEN-1:0] dmem_wd,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] c_SZ_B = 2'b00;
  localparam logic [1:0] c_SZ_H = 2'b01;
  localparam logic [1:0] c_SZ_W = 2'b10;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic              r_err;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_merge;

  logic              w_accept;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_err;
  logic [XLEN-1:0]   w_addr_eff;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;
  logic [XLEN-1:0]   w_merge;
  logic [XLEN-1:0]   w_word_addr;

  assign w_accept    = req_valid & req_ready;
  assign w_word_addr = {r_addr[XLEN-1:2], 2'b00};

  // Classify the incoming request and compute its naturally aligned address
  always_comb begin
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    w_addr_eff = req_addr;
    case (req_funct3[1:0])
      c_SZ_H: begin
        w_misalign = req_addr[0];
        w_addr_eff = {req_addr[XLEN-1:1], 1'b0};
      end
      c_SZ_W: begin
        w_misalign = (req_addr[1:0] != 2'b00);
        w_addr_eff = {req_addr[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
    // 011, 110, 111 are undefined; BU/HU exist only as loads
    if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]))
      w_illegal = 1'b1;
    // With misalign errors disabled the masked address is simply used
    w_err = w_illegal | (ERR_ON_MISALIGN & w_misalign);
  end

  // Lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    w_byte      = dmem_rd[{r_addr[1:0], 3'b000} +: 8];
    w_half      = dmem_rd[{r_addr[1], 4'b0000} +: 16];
    w_load_data = dmem_rd;
    case (r_funct3)
      3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_data = dmem_rd;
    endcase
    w_merge = dmem_rd;
    if (r_funct3[1:0] == c_SZ_B)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request latch, load result and merge word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_merge  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= w_addr_eff;
        r_funct3 <= req_funct3;
        r_we     <= req_we;
        r_wdata  <= req_wdata;
        r_err    <= w_err;
        r_rdata  <= '0;
      end else if (r_state == S_ACCESS) begin
        if (!r_we) r_rdata <= w_load_data;
        else       r_merge <= w_merge;
      end
    end
  end

  // Next-state and output decode; rstn gates the outputs so a reset drops them at once
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    dmem_a      = '0;
    dmem_we     = 1'b0;
    dmem_wd     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = rstn;
        if (w_accept) w_state_nxt = w_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        dmem_a = w_word_addr;
        if (r_we && (r_funct3[1:0] == c_SZ_W)) begin
          dmem_we     = rstn;
          dmem_wd     = r_wdata;
          w_state_nxt = S_RESP;
        end else if (r_we) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_WRITE: begin
        dmem_a      = w_word_addr;
        dmem_we     = rstn;
        dmem_wd     = r_merge;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        dmem_a      = w_word_addr;
        resp_valid  = 1'b1;
        resp_err    = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!dmem_we) dmem_wd = '0;
  end

  assign resp_rdata = r_rdata;

endmodule
`default_nettype wire
